io_debounce: RTL and testbench

- Conditions the NUM_CH slide-switch inputs on the board wrapper before they reach the fabric's O_top switch lanes.
- Per channel: an N-flop synchroniser, a counter-based debounce FSM, and one-cycle rise/fall strobes.
- Runs in the 12.5 MHz system clock domain, downstream of the raw user_io switch pins and upstream of the fabric top.

---
 rtl/io_debounce_pkg.sv | 14 +
 rtl/io_debounce_ch.sv | 119 +++++++++++
 rtl/io_debounce.sv | 45 ++++
 tb/tb_io_debounce.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// The optional toggle output is enabled with the IO_DEBOUNCE_TOGGLE_EN macro.
package io_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LO,
        PEND_HI,
        ST_HI,
        PEND_LO
    } deb_state_t;

    localparam int DEB_10MS_AT_12M5 = 125000;

endpackage

// File: rtl/io_debounce_ch.sv
// One switch channel: synchroniser, counter-based debounce FSM and edge strobes.
// With IO_DEBOUNCE_TOGGLE_EN defined, it also provides a push-on/push-off toggle bit.
module io_debounce_ch
    import io_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEB_10MS_AT_12M5
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
`ifdef IO_DEBOUNCE_TOGGLE_EN
    output logic toggle,
`endif
    output logic pend
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    deb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ST_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter restarts at 1 on entry to a pending state, so a change is
    // accepted once DEBOUNCE_CYCLES+1 consecutive synced samples agree.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (sync) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_HI: begin
                if (!sync) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!sync) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND_LO: begin
                if (sync) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    assign stable = (state_q == ST_HI) || (state_q == PEND_LO);
    assign pend   = (state_q == PEND_HI) || (state_q == PEND_LO);
    assign rise   = rise_q;
    assign fall   = fall_q;

`ifdef IO_DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_q ^ rise_q;
        end
    end

    assign toggle = toggle_q;
`endif

endmodule

// File: rtl/io_debounce.sv
// Debounces NUM_CH slide switches in the system clock domain.
// Defining IO_DEBOUNCE_TOGGLE_EN adds the toggle_o push-on/push-off outputs.
module io_debounce
    import io_debounce_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEB_10MS_AT_12M5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] stable_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
`ifdef IO_DEBOUNCE_TOGGLE_EN
    output logic [NUM_CH-1:0] toggle_o,
`endif
    output logic              busy_o
);

    logic [NUM_CH-1:0] pend;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        io_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_i[c]),
            .stable(stable_o[c]),
            .rise  (rise_o[c]),
            .fall  (fall_o[c]),
`ifdef IO_DEBOUNCE_TOGGLE_EN
            .toggle(toggle_o[c]),
`endif
            .pend  (pend[c])
        );
    end

    // pend is decoded from registered FSM state, so busy_o tracks post-edge state.
    assign busy_o = |pend;

endmodule

// File: tb/tb_io_debounce.sv
// Self-checking bench for io_debounce against a run-length reference model.
// Define IO_DEBOUNCE_TOGGLE_EN to also exercise toggle_o.
module tb_io_debounce;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int LAT  = SYNC + DEB;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] raw = '0;
    logic [NCH-1:0] stable, rise, fall;
    logic           busy;
`ifdef IO_DEBOUNCE_TOGGLE_EN
    logic [NCH-1:0] toggle;
`endif

    int checks = 0;
    int errors = 0;

    logic [NCH-1:0] exp_stable, exp_rise, exp_fall, exp_toggle;
    logic           exp_busy;
    logic [NCH-1:0] pipe [SYNC];
    int             run [NCH];

    always #40 clk = ~clk;

    io_debounce #(
        .NUM_CH         (NCH),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_i   (raw),
        .stable_o(stable),
        .rise_o  (rise),
        .fall_o  (fall),
`ifdef IO_DEBOUNCE_TOGGLE_EN
        .toggle_o(toggle),
`endif
        .busy_o  (busy)
    );

    // Reference: a level is accepted once DEB+1 consecutive synced samples
    // disagree with the current level; the synced sample lags raw by SYNC edges.
    task automatic model_edge();
        logic [NCH-1:0] s;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) pipe[i] = '0;
            for (int c = 0; c < NCH; c++) run[c] = 0;
            exp_stable = '0; exp_rise = '0; exp_fall = '0;
            exp_busy = 1'b0; exp_toggle = '0;
        end else begin
            exp_toggle = exp_toggle ^ exp_rise;
            s = pipe[SYNC-1];
            exp_rise = '0;
            exp_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                if (s[c] !== exp_stable[c]) begin
                    run[c]++;
                    if (run[c] == DEB + 1) begin
                        exp_rise[c]   = s[c];
                        exp_fall[c]   = ~s[c];
                        exp_stable[c] = s[c];
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            for (int i = SYNC - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = raw;
            exp_busy = 1'b0;
            for (int c = 0; c < NCH; c++) if (run[c] > 0) exp_busy = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw = '0;
        repeat (3) step();
        if ({stable, rise, fall, busy} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b required %b", {stable, rise, fall, busy}, 13'b0);
        end
        checks++;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL idle_hold cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
        end
    endtask

    task automatic test_rise_latency();
        int lat = -1;
        int busy_cycles = 0;
        raw[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL rise_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if (lat < 0 && busy) busy_cycles++;
            if (lat < 0 && rise[0]) lat = k - 1;
        end
        if (lat !== LAT) begin
            errors++;
            $display("[TB] FAIL rise_latency: got %0d required %0d", lat, LAT);
        end
        checks++;
        if (busy_cycles !== DEB) begin
            errors++;
            $display("[TB] FAIL rise_busy_cycles: got %0d required %0d", busy_cycles, DEB);
        end
        checks++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        raw[1] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) raw[1] = 1'b0;
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL glitch_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if (stable[1] || rise[1] || fall[1]) pulses++;
        end
        if (pulses !== 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_reject: got pulses=%0d busy=%b required 0 0", pulses, busy);
        end
        checks++;
    endtask

    task automatic test_all_channels();
        logic [NCH-1:0] rise_seen = '0;
        int fall_lat = -1;
        int fall_count = 0;
        raw = '0;
        repeat (20) step();
        raw = '1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL all_rise_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if (rise !== '0 && rise_seen == '0) rise_seen = rise;
        end
        if (rise_seen !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL all_rise_simultaneous: got %b required %b", rise_seen, 4'b1111);
        end
        checks++;
        raw[2] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL ch2_fall_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if (fall !== '0) fall_count++;
            if (fall_lat < 0 && fall[2]) fall_lat = k - 1;
        end
        if (fall_lat !== LAT || fall_count !== 1 || stable !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL ch2_fall: got lat=%0d pulses=%0d stable=%b required lat=%0d pulses=1 stable=1011",
                     fall_lat, fall_count, stable, LAT);
        end
        checks++;
    endtask

    task automatic test_reset_mid_pend();
        int lat = -1;
        int early = 0;
        raw = '0;
        repeat (20) step();
        raw[3] = 1'b1;
        repeat (SYNC + 4) step();
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pend_before_reset: got busy=%b required 1", busy);
        end
        checks++;
        reset = 1'b1;
        repeat (2) step();
        if (rise[3] || stable[3]) early++;
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL mid_pend_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if (lat < 0 && rise[3]) lat = k - 1;
        end
        if (lat !== LAT || early !== 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_pend: got lat=%0d early=%0d required lat=%0d early=0", lat, early, LAT);
        end
        checks++;
    endtask

    task automatic test_random();
        int hold [NCH];
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 16);
                end
                hold[c]--;
            end
            step();
            if ({stable, rise, fall, busy} !== {exp_stable, exp_rise, exp_fall, exp_busy}) begin
                errors++;
                $display("[TB] FAIL random_model cyc %0d: got %b required %b", k,
                         {stable, rise, fall, busy}, {exp_stable, exp_rise, exp_fall, exp_busy});
            end
            checks++;
            if ((rise & fall) !== '0) begin
                errors++;
                $display("[TB] FAIL rise_fall_exclusive cyc %0d: got %b required 0000", k, rise & fall);
            end
            checks++;
        end
    endtask

`ifdef IO_DEBOUNCE_TOGGLE_EN
    task automatic test_toggle();
        int presses = 0;
        logic prev_rise = 1'b0;
        logic prev_tog = 1'b0;
        reset = 1'b1;
        raw = '0;
        repeat (2) step();
        reset = 1'b0;
        for (int k = 0; k < 80; k++) begin
            raw[0] = ((k / 20) % 2 == 0) ? 1'b1 : 1'b0;
            step();
            if (toggle !== exp_toggle) begin
                errors++;
                $display("[TB] FAIL toggle_model cyc %0d: got %b required %b", k, toggle, exp_toggle);
            end
            checks++;
            if (prev_rise) begin
                presses++;
                if (toggle[0] !== ~prev_tog) begin
                    errors++;
                    $display("[TB] FAIL toggle_flip press %0d: got %b required %b", presses, toggle[0], ~prev_tog);
                end
                checks++;
            end
            prev_rise = rise[0];
            prev_tog  = toggle[0];
        end
        if (presses !== 2 || toggle[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL toggle_presses: got presses=%0d toggle=%b required 2 0", presses, toggle[0]);
        end
        checks++;
    endtask
`endif

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_all_channels();
        test_reset_mid_pend();
        test_random();
`ifdef IO_DEBOUNCE_TOGGLE_EN
        test_toggle();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
